// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: splits one linear read command into INCR bursts that are
// capped at 2^LEN_WIDTH beats and never cross a 4 KB page, and forwards the
// returned beats as a ready/valid stream.
module axi_rd_burst_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned SIZE_WIDTH = 3,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  // command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [CNT_WIDTH-1:0]    cmd_beats,
  // AR channel
  output logic [ID_WIDTH-1:0]     ARID,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [LEN_WIDTH-1:0]    ARLEN,
  output logic [SIZE_WIDTH-1:0]   ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARLOCK,
  output logic [3:0]              ARCACHE,
  output logic [2:0]              ARPROT,
  output logic [3:0]              ARQOS,
  output logic [3:0]              ARREGION,
  output logic                    ARUSER,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  // R channel
  input  logic [ID_WIDTH-1:0]     RID,
  input  logic [STRB_WIDTH*8-1:0] RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY,
  // output stream
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [STRB_WIDTH*8-1:0] out_data,
  output logic                    out_last,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned SizeLog2 = $clog2(STRB_WIDTH);
  localparam int unsigned MaxBurst = 1 << LEN_WIDTH;
  localparam logic [LEN_WIDTH:0] BurstOne = 1;
  localparam logic [CNT_WIDTH-1:0] CntOne = 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;    // address of the next beat to be requested/received
  logic [CNT_WIDTH-1:0]  remain_q;  // beats left in the whole command
  logic [LEN_WIDTH:0]    burst_q;   // beats left in the current burst
  logic [LEN_WIDTH-1:0]  arlen_q;
  logic                  arvalid_q;
  logic                  done_q;
  logic                  err_q;

  // Beats in the next burst: min(remaining, max burst, beats left in the 4 KB page).
  function automatic logic [LEN_WIDTH:0] burst_beats(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0]  n);
    logic [ADDR_WIDTH-1:0] page;
    logic [ADDR_WIDTH-1:0] lim;
    logic [ADDR_WIDTH-1:0] rem;
    page = (ADDR_WIDTH'(4096) - ADDR_WIDTH'(a[11:0])) >> SizeLog2;
    lim  = ADDR_WIDTH'(MaxBurst);
    rem  = ADDR_WIDTH'(n);
    if (page < lim) lim = page;
    if (rem < lim) lim = rem;
    return lim[LEN_WIDTH:0];
  endfunction

  logic                  in_data;
  logic                  beat;
  logic                  burst_end;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [CNT_WIDTH-1:0]  remain_nxt;
  logic [LEN_WIDTH:0]    next_beats;
  logic [LEN_WIDTH:0]    first_beats;
  logic                  unused_rid;

  assign in_data     = (state_q == StData);
  assign beat        = in_data & RVALID & out_ready;
  assign burst_end   = (burst_q == BurstOne);
  assign addr_nxt    = addr_q + ADDR_WIDTH'(STRB_WIDTH);
  assign remain_nxt  = remain_q - CntOne;
  assign next_beats  = burst_beats(addr_nxt, remain_nxt);
  assign first_beats = burst_beats(cmd_addr, cmd_beats);
  assign unused_rid  = ^RID;

  assign cmd_ready = (state_q == StIdle) & ~rst;

  assign ARID     = '0;
  assign ARADDR   = addr_q;  // only advances in DATA, so stable while ARVALID is high
  assign ARLEN    = arlen_q;
  assign ARSIZE   = SIZE_WIDTH'(SizeLog2);
  assign ARBURST  = 2'b01;
  assign ARLOCK   = 1'b0;
  assign ARCACHE  = 4'b0011;
  assign ARPROT   = 3'b000;
  assign ARQOS    = 4'b0000;
  assign ARREGION = 4'b0000;
  assign ARUSER   = 1'b0;
  assign ARVALID  = arvalid_q;

  // R data passes straight through to the stream with no added latency
  assign RREADY    = in_data & out_ready;
  assign out_valid = in_data & RVALID;
  assign out_data  = RDATA;
  assign out_last  = in_data & (remain_q == CntOne);
  assign done      = done_q;
  assign err       = err_q;

  // Command FSM: issues one burst at a time, counts beats, flags response/RLAST errors
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      remain_q  <= '0;
      burst_q   <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            remain_q <= cmd_beats;
            err_q    <= 1'b0;
            if (cmd_beats == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StAddr;
              arvalid_q <= 1'b1;
              burst_q   <= first_beats;
              arlen_q   <= LEN_WIDTH'(first_beats - BurstOne);
            end
          end
        end
        StAddr: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (beat) begin
            addr_q   <= addr_nxt;
            remain_q <= remain_nxt;
            burst_q  <= burst_q - BurstOne;
            // The internal count decides burst boundaries; RLAST is only checked.
            if ((RRESP != 2'b00) || (RLAST != burst_end)) err_q <= 1'b1;
            if (burst_end) begin
              if (remain_nxt != '0) begin
                state_q   <= StAddr;
                arvalid_q <= 1'b1;
                burst_q   <= next_beats;
                arlen_q   <= LEN_WIDTH'(next_beats - BurstOne);
              end else begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Directed bench for axi_rd_burst_master with a small in-bench AXI read slave.
module tb_axi_rd_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic [0:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [3:0]  ARQOS;
  logic [3:0]  ARREGION;
  logic        ARUSER;
  logic        ARVALID;
  logic        ARREADY;
  logic [0:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        done;
  logic        err;

  axi_rd_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS), .ARREGION(ARREGION),
    .ARUSER(ARUSER), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the most recent command
  logic [31:0] ar_addr[$];
  logic [3:0]  ar_len[$];
  int rx, done_cyc, last_beat_cyc, err_first_cyc, err_beat_cyc, ar_hs_cyc, stall_seen;
  bit err_fell, err_at_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, a};
  endfunction

  task automatic check_ar(input int i, input logic [31:0] ea, input logic [3:0] el);
    if (i < ar_addr.size()) begin
      check("ar_addr", 64'(ar_addr[i]), 64'(ea));
      check("ar_len", 64'(ar_len[i]), 64'(el));
    end else begin
      check("ar_count", 64'(ar_addr.size()), 64'(i + 1));
    end
  endtask

  // Runs one command cycle by cycle: inputs driven after negedge, outputs sampled 1 ns later.
  task automatic do_cmd(input logic [31:0] a, input int n, input int stall, input bit toggle,
                        input int err_beat, input bit bad_rlast, input int rst_at);
    logic [31:0] s_addr = '0;
    int          s_left = 0;
    int          ar_wait = 0;
    int          rst_phase = 0;
    bit          stalled = 1'b0;
    bit          fin = 1'b0;
    logic [31:0] p_addr = '0;
    logic [3:0]  p_len = '0;
    ar_addr.delete();
    ar_len.delete();
    rx = 0; done_cyc = -1; last_beat_cyc = -1; err_first_cyc = -1; err_beat_cyc = -1;
    ar_hs_cyc = -1; stall_seen = 0; err_fell = 1'b0; err_at_done = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      if (rst_phase == 0 && rst_at >= 0 && rx == rst_at) rst_phase = 1;
      rst       = (rst_phase == 1);
      cmd_valid = (cyc == 0);
      cmd_addr  = a;
      cmd_beats = 16'(n);
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      ARREADY   = (ar_wait >= stall);
      RVALID    = (s_left > 0);
      RDATA     = RVALID ? mem_word(s_addr) : '0;
      RLAST     = RVALID && !bad_rlast && (s_left == 1);
      RRESP     = (RVALID && rx == err_beat) ? 2'b10 : 2'b00;
      #1;
      if (rst_phase == 1) begin
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        s_left    = 0;
        rst_phase = 2;
      end else if (rst_phase == 2) begin
        check("post_rst_arvalid", 64'(ARVALID), 64'(0));
        check("post_rst_rready", 64'(RREADY), 64'(0));
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        fin = 1'b1;
      end else begin
        if (cyc == 0) check("cmd_ready", 64'(cmd_ready), 64'(1));
        if (cyc == 1) check("err_cleared", 64'(err), 64'(0));
        if (stalled) begin
          check("arvalid_hold", 64'(ARVALID), 64'(1));
          check("araddr_hold", 64'(ARADDR), 64'(p_addr));
          check("arlen_hold", 64'(ARLEN), 64'(p_len));
        end
        stalled = ARVALID && !ARREADY;
        if (stalled) begin
          stall_seen++;
          ar_wait++;
          p_addr = ARADDR;
          p_len  = ARLEN;
        end
        if (RVALID) begin
          check("rready_mirror", 64'(RREADY), 64'(out_ready));
          check("out_valid", 64'(out_valid), 64'(1));
          if (RREADY) begin
            check("out_data", out_data, mem_word(a + 32'(rx) * 32'd8));
            check("out_last", 64'(out_last), 64'(rx == n - 1));
            if (rx == err_beat) err_beat_cyc = cyc;
            rx++;
            last_beat_cyc = cyc;
            s_addr += 32'd8;
            s_left--;
          end
        end else begin
          check("out_valid_idle", 64'(out_valid), 64'(0));
        end
        if (ARVALID && ARREADY) begin
          ar_addr.push_back(ARADDR);
          ar_len.push_back(ARLEN);
          if (ar_hs_cyc < 0) ar_hs_cyc = cyc;
          ar_wait = 0;
          s_addr  = ARADDR;
          s_left  = int'(ARLEN) + 1;
        end
        if (err && err_first_cyc < 0) err_first_cyc = cyc;
        if (!err && err_first_cyc >= 0) err_fell = 1'b1;
        if (done) begin
          done_cyc    = cyc;
          err_at_done = err;
          fin         = 1'b1;
        end
      end
    end
    check("cmd_completed", 64'(fin), 64'(1));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; ARREADY = 1'b0;
    RID = '0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_arvalid", 64'(ARVALID), 64'(0));
    check("rst_rready", 64'(RREADY), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;

    // 40 beats from 0x1000: 16 + 16 + 8
    do_cmd(32'h1000, 40, 0, 1'b0, -1, 1'b0, -1);
    check("t1_ar_n", 64'(ar_addr.size()), 64'(3));
    check_ar(0, 32'h1000, 4'd15);
    check_ar(1, 32'h1080, 4'd15);
    check_ar(2, 32'h1100, 4'd7);
    check("t1_beats", 64'(rx), 64'(40));
    check("t1_done_lat", 64'(done_cyc), 64'(last_beat_cyc + 1));
    check("t1_err", 64'(err_at_done), 64'(0));

    // 4 KB boundary split
    do_cmd(32'h0FC0, 16, 0, 1'b0, -1, 1'b0, -1);
    check("t2_ar_n", 64'(ar_addr.size()), 64'(2));
    check_ar(0, 32'h0FC0, 4'd7);
    check_ar(1, 32'h1000, 4'd7);
    check("t2_beats", 64'(rx), 64'(16));

    // ARREADY low for 5 cycles
    do_cmd(32'h2000, 4, 5, 1'b0, -1, 1'b0, -1);
    check("t3_ar_n", 64'(ar_addr.size()), 64'(1));
    check_ar(0, 32'h2000, 4'd3);
    check("t3_stall_cycles", 64'(stall_seen), 64'(5));
    check("t3_hs_cycle", 64'(ar_hs_cyc), 64'(6));
    check("t3_beats", 64'(rx), 64'(4));

    // out_ready toggling
    do_cmd(32'h3000, 20, 0, 1'b1, -1, 1'b0, -1);
    check("t4_ar_n", 64'(ar_addr.size()), 64'(2));
    check_ar(0, 32'h3000, 4'd15);
    check_ar(1, 32'h3080, 4'd3);
    check("t4_beats", 64'(rx), 64'(20));

    // SLVERR on beat 3 of 8
    do_cmd(32'h4000, 8, 0, 1'b0, 2, 1'b0, -1);
    check("t5_beats", 64'(rx), 64'(8));
    check("t5_err_start", 64'(err_first_cyc), 64'(err_beat_cyc + 1));
    check("t5_err_sticky", 64'(err_fell), 64'(0));
    check("t5_err_done", 64'(err_at_done), 64'(1));

    // next command clears err
    do_cmd(32'h5000, 1, 0, 1'b0, -1, 1'b0, -1);
    check_ar(0, 32'h5000, 4'd0);
    check("t5b_err_done", 64'(err_at_done), 64'(0));

    // zero-beat command
    do_cmd(32'h6000, 0, 0, 1'b0, -1, 1'b0, -1);
    check("t6_ar_n", 64'(ar_addr.size()), 64'(0));
    check("t6_done_lat", 64'(done_cyc), 64'(1));

    // reset in the middle of DATA
    do_cmd(32'h6100, 16, 0, 1'b0, -1, 1'b0, 3);
    check("t7_beats", 64'(rx), 64'(3));
    check("t7_ar_n", 64'(ar_addr.size()), 64'(1));

    // RLAST never asserted: command still completes by count, err set
    do_cmd(32'h7000, 2, 0, 1'b0, -1, 1'b1, -1);
    check_ar(0, 32'h7000, 4'd1);
    check("t8_beats", 64'(rx), 64'(2));
    check("t8_err_done", 64'(err_at_done), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
